execute_muldiv: RTL
===================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have ports: clk_i  input  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: E_start_i  input  1  valid RV32M instruction resident in execute (from decode register outputs).
REQ-004 SHALL have ports: E_funct3_i  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have ports: E_rs1_data_i / E_rs2_data_i  input  `XLEN (32) each  operands.
REQ-006 SHALL have ports: E_flush_i  input  1  abort current op (branch mispredict squash).
REQ-007 SHALL have ports: E_stall_o  output  1  hold decode register and upstream (drives D_stall_i).
REQ-008 SHALL have ports: E_done_o  output  1  one-cycle pulse, E_result_o valid.
REQ-009 SHALL have ports: E_result_o  output  `XLEN  registered result.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 SHALL, in IDLE with E_start_i=1, latch operands/op, clear 6-bit counter, go BUSY; else stay IDLE.
REQ-012 SHALL, in BUSY, perform one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle; after 32 steps (counter 31) go DONE.
REQ-013 SHALL, in DONE, assert E_done_o=1, E_stall_o=0, return to IDLE next cycle unconditionally.
REQ-014 SHALL drive E_stall_o = (IDLE & E_start_i) | BUSY, combinationally; E_stall_o=0 in DONE so the pipeline advances exactly once.
REQ-015 SHALL give total latency: start seen cycle 0, BUSY cycles 1..32, E_done_o cycle 33.
REQ-016 SHALL convert signed operands to magnitude on entry, apply sign fixup at DONE: quotient negative iff signs differ; remainder takes dividend sign; MULH/MULHSU use 64-bit signed product.
REQ-017 SHALL return upper 32 bits of 64-bit product for MULH/MULHSU/MULHU, lower 32 for MUL.
REQ-018 SHALL short-circuit divide-by-zero (rs2=0): IDLE->DONE next cycle; DIV/DIVU result 0xFFFFFFFF, REM/REMU result rs1.
REQ-019 SHALL short-circuit signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): IDLE->DONE next cycle; DIV result 0x80000000, REM result 0.
REQ-020 SHALL, on E_flush_i=1 in any state, go IDLE next cycle, suppress E_done_o, leave E_result_o unchanged; flush beats start in same cycle.
REQ-021 SHALL hold E_result_o stable between done pulses.
REQ-022 SHALL ignore E_funct3_i/operand changes while BUSY.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, set state IDLE, counter 0, E_done_o 0, E_result_o 0, internal operand/accumulator registers 0; rst beats flush and start.
REQ-024 SHALL, on reset mid-BUSY, discard the op; E_stall_o=0 in the cycle after reset unless E_start_i=1.

Configuration
REQ-025 SHALL support macro MULDIV_FAST_MUL_EN: defined -> MUL/MULH/MULHSU/MULHU computed with one-cycle 33x33 signed multiplier, IDLE->DONE directly (latency 1 stall cycle); undefined -> multiplies take iterative 32-step path (REQ-012); divides iterative in both cases.

Verification
REQ-026 SHALL pass: DIVU 100/7 start cycle 0 -> E_stall_o 1 cycles 0..32, E_done_o cycle 33, result 14; REMU -> 2.
REQ-027 SHALL pass: DIV 0xFFFFFF9C (-100)/7 -> 0xFFFFFFF2 (-14); REM -> 0xFFFFFFFE (-2).
REQ-028 SHALL pass: DIV 5/0 -> done cycle 1, result 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done cycle 1.
REQ-029 SHALL pass: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL -> 0x00000001; done cycle 33 without macro, cycle 1 with MULDIV_FAST_MUL_EN.
REQ-030 SHALL pass: E_flush_i at cycle 10 of DIVU -> IDLE cycle 11, no done pulse, E_result_o unchanged; new start cycle 11 completes normally.
REQ-031 SHALL pass: rst at cycle 5 of DIV -> E_done_o 0, E_result_o 0, state IDLE; back-to-back starts produce exactly one done pulse each.

Source files
------------

// File: rtl/execute_muldiv.sv
// RV32M multiply/divide unit for the execute stage: 32-step shift-add / restoring divide FSM.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle instead.
`ifndef XLEN
`define XLEN 32
`endif

module execute_muldiv (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              E_start_i,
    input  logic [2:0]        E_funct3_i,
    input  logic [`XLEN-1:0]  E_rs1_data_i,
    input  logic [`XLEN-1:0]  E_rs2_data_i,
    input  logic              E_flush_i,
    output logic              E_stall_o,
    output logic              E_done_o,
    output logic [`XLEN-1:0]  E_result_o
);
    localparam int W = `XLEN;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    result_q, result_d;

    // Incoming-op decode
    logic            is_div_in, sa_in, sb_in, neg_in, div0_in, ovf_in, short_in;
    logic [W-1:0]    mag1_in, mag2_in, short_res_in;

    always_comb begin
        is_div_in = E_funct3_i[2];
        sa_in     = ((E_funct3_i == 3'd1) || (E_funct3_i == 3'd2) ||
                     (E_funct3_i == 3'd4) || (E_funct3_i == 3'd6)) && E_rs1_data_i[W-1];
        sb_in     = ((E_funct3_i == 3'd1) || (E_funct3_i == 3'd4) ||
                     (E_funct3_i == 3'd6)) && E_rs2_data_i[W-1];
        mag1_in   = sa_in ? -E_rs1_data_i : E_rs1_data_i;
        mag2_in   = sb_in ? -E_rs2_data_i : E_rs2_data_i;
        // Remainder follows the dividend; everything else follows the sign product
        neg_in    = (E_funct3_i == 3'd6) ? sa_in : (sa_in ^ sb_in);
        div0_in   = is_div_in && (E_rs2_data_i == '0);
        ovf_in    = ((E_funct3_i == 3'd4) || (E_funct3_i == 3'd6)) &&
                    (E_rs1_data_i == {1'b1, {(W-1){1'b0}}}) && (E_rs2_data_i == '1);
        short_in  = div0_in || ovf_in;
        if (div0_in)
            short_res_in = E_funct3_i[1] ? E_rs1_data_i : '1;
        else
            short_res_in = E_funct3_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic                  fast_in;
    logic signed [2*W-1:0] fa, fb, fprod;
    logic [W-1:0]          fast_res;

    always_comb begin
        fast_in  = !is_div_in;
        fa       = {{W{sa_in ? 1'b1 : ((E_funct3_i == 3'd1 || E_funct3_i == 3'd2) && E_rs1_data_i[W-1])}}, E_rs1_data_i};
        fb       = {{W{(E_funct3_i == 3'd1) && E_rs2_data_i[W-1]}}, E_rs2_data_i};
        fprod    = fa * fb;
        fast_res = (E_funct3_i == 3'd0) ? fprod[W-1:0] : fprod[2*W-1:W];
    end
`endif

    // One iteration of the shift-add / restoring-subtract datapath
    logic [W:0]      mul_add, div_trial;
    logic            div_ge;
    logic [W-1:0]    div_rem;
    logic [2*W-1:0]  step_nxt, prod_fix;
    logic [W-1:0]    quo_fix, rem_fix, fin_res;

    always_comb begin
        mul_add   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
        div_ge    = ~div_trial[W];
        div_rem   = div_ge ? div_trial[W-1:0] : acc_q[2*W-2:W-1];
        step_nxt  = op_q[2] ? {div_rem, acc_q[W-2:0], div_ge} : {mul_add, acc_q[W-1:1]};
        prod_fix  = neg_q ? -step_nxt : step_nxt;
        quo_fix   = neg_q ? -step_nxt[W-1:0] : step_nxt[W-1:0];
        rem_fix   = neg_q ? -step_nxt[2*W-1:W] : step_nxt[2*W-1:W];
        if (op_q[2])
            fin_res = op_q[1] ? rem_fix : quo_fix;
        else
            fin_res = (op_q == 3'd0) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end

    always_ff @(posedge clk_i) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (E_start_i) begin
`ifdef MULDIV_FAST_MUL_EN
                state_d = (short_in || fast_in) ? S_DONE : S_BUSY;
`else
                state_d = short_in ? S_DONE : S_BUSY;
`endif
            end
            S_BUSY: if (cnt_q == 6'd31) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (E_flush_i) state_d = S_IDLE;
    end

    always_comb begin
        E_stall_o = ((state_q == S_IDLE) && E_start_i) || (state_q == S_BUSY);
        E_done_o  = (state_q == S_DONE) && !E_flush_i;
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (!E_flush_i) begin
            if (state_q == S_IDLE && E_start_i) begin
                op_d  = E_funct3_i;
                cnt_d = '0;
                neg_d = neg_in;
                if (is_div_in) begin
                    opnd_d = mag2_in;
                    acc_d  = {{W{1'b0}}, mag1_in};
                end else begin
                    opnd_d = mag1_in;
                    acc_d  = {{W{1'b0}}, mag2_in};
                end
                if (short_in) result_d = short_res_in;
`ifdef MULDIV_FAST_MUL_EN
                if (fast_in) result_d = fast_res;
`endif
            end else if (state_q == S_BUSY) begin
                acc_d = step_nxt;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) result_d = fin_res;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign E_result_o = result_q;
endmodule
